// File: rtl/tube_slave_seq_pkg.sv
// Shared state encodings, arbiter grant constants and a sizing helper for the tube slave sequencer.
package tube_slave_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_SETUP = 3'd1,
    S_WR_PULSE = 3'd2,
    S_WR_HOLD  = 3'd3,
    S_RD_PULSE = 3'd4,
    S_SETTLE   = 3'd5
  } state_t;

  localparam logic GRANT_TX = 1'b0;
  localparam logic GRANT_RX = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tube_slave_seq_timer.sv
// Loadable down-counter timing the pulse and settle phases; done is high while the count is zero.
module tube_slave_seq_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic          o_done
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/tube_slave_seq.sv
// Slave-side byte-latch sequencer: round-robin tx/rx arbitration, registered strobes, tx-stall watchdog.
// tx_ready pulses 2+WR_PULSE cycles after grant; rx is held off while the single rx holding register is full.
module tube_slave_seq
  import tube_slave_seq_pkg::*;
#(
  parameter int WR_PULSE  = 2,
  parameter int RD_PULSE  = 2,
  parameter int SETTLE    = 2,
  parameter int TIMEOUT_W = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic       slave_dir,
  input  logic       slave_dor,
  input  logic [7:0] slave_data_i,
  output logic [7:0] slave_data_o,
  output logic       slave_data_oe,
  output logic       slave_wr,
  output logic       slave_rd_b,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam int CW = $clog2(max3(WR_PULSE, RD_PULSE, SETTLE)) + 1;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               r_state, w_next;
  logic                 r_last_grant;
  logic                 w_tx_el, w_rx_el, w_grant_vld, w_grant_tx;
  logic                 w_tmr_load, w_tmr_done;
  logic [CW-1:0]        w_tmr_val;
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 w_wd_run, w_wd_hit;
  logic                 r_tx_ready, r_slave_wr, r_rd_b, r_oe, r_busy, r_rx_valid, r_err;
  logic [7:0]           r_data_o, r_rx_data;

  assign w_tx_el = tx_valid & slave_dir;
  assign w_rx_el = slave_dor & ~r_rx_valid;

  always_comb begin
    w_next      = r_state;
    w_grant_vld = 1'b0;
    w_grant_tx  = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_tx_el && (!w_rx_el || r_last_grant == GRANT_RX)) begin
          w_grant_vld = 1'b1;
          w_grant_tx  = 1'b1;
          w_next      = S_WR_SETUP;
        end else if (w_rx_el) begin
          w_grant_vld = 1'b1;
          w_next      = S_RD_PULSE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = CW'(RD_PULSE - 1);
        end
      end
      S_WR_SETUP: begin
        w_next     = S_WR_PULSE;
        w_tmr_load = 1'b1;
        w_tmr_val  = CW'(WR_PULSE - 1);
      end
      S_WR_PULSE: if (w_tmr_done) w_next = S_WR_HOLD;
      S_WR_HOLD: begin
        w_next     = S_SETTLE;
        w_tmr_load = 1'b1;
        w_tmr_val  = CW'(SETTLE - 1);
      end
      S_RD_PULSE: begin
        if (w_tmr_done) begin
          w_next     = S_SETTLE;
          w_tmr_load = 1'b1;
          w_tmr_val  = CW'(SETTLE - 1);
        end
      end
      S_SETTLE: if (w_tmr_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  tube_slave_seq_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_done (w_tmr_done)
  );

  // Strobes are registered from the next state so every latch control comes straight off a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_RX;
      r_tx_ready   <= 1'b0;
      r_slave_wr   <= 1'b0;
      r_rd_b       <= 1'b1;
      r_oe         <= 1'b0;
      r_busy       <= 1'b0;
      r_data_o     <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tx_ready <= (w_next == S_WR_HOLD);
      r_slave_wr <= (w_next == S_WR_PULSE);
      r_rd_b     <= (w_next != S_RD_PULSE);
      r_oe       <= (w_next == S_WR_SETUP) || (w_next == S_WR_PULSE) || (w_next == S_WR_HOLD);
      r_busy     <= (w_next != S_IDLE);
      if (w_grant_vld) r_last_grant <= w_grant_tx ? GRANT_TX : GRANT_RX;
      if (w_grant_tx) r_data_o <= tx_data;
      if (r_state == S_RD_PULSE && w_tmr_done) begin
        r_rx_data  <= slave_data_i;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  // The error fires on the step into all-ones, so a saturated counter does not re-raise it after err_clr.
  assign w_wd_run = tx_valid & ~slave_dir & (r_state == S_IDLE);
  assign w_wd_hit = w_wd_run && (r_wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (!w_wd_run) r_wd <= '0;
      else if (!(&r_wd)) r_wd <= r_wd + 1'b1;
      if (w_wd_hit) r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

  a_oe_rd_excl: assert property (@(posedge clk) disable iff (reset) !(r_oe && !r_rd_b));

  assign tx_ready      = r_tx_ready;
  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign slave_data_o  = r_data_o;
  assign slave_data_oe = r_oe;
  assign slave_wr      = r_slave_wr;
  assign slave_rd_b    = r_rd_b;
  assign busy          = r_busy;
  assign timeout_err   = r_err;

endmodule
